// File: rtl/clks_alot_p.sv
`default_nettype none
// ============================================================================
// clks_alot_p: widths, generator state and pending-update type for clks_alot.
// Rev 1.0
// ============================================================================
package clks_alot_p;

  localparam int COUNTER_WIDTH = 8;
  localparam int SKEW_WIDTH    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } gen_state_e;

  typedef struct packed {
    logic                     valid;
    logic [COUNTER_WIDTH-1:0] value;
  } pend_s;

endpackage
`default_nettype wire

// File: rtl/common_p.sv
`default_nettype none
// ============================================================================
// common_p: shared clock-domain bundle type.
// Rev 1.0
// ============================================================================
package common_p;

  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom_s;

endpackage
`default_nettype wire

// File: rtl/half_period_counter.sv
`default_nettype none
// ============================================================================
// half_period_counter: half-period position counter with clamped target.
// Rev 1.0
// ============================================================================
module half_period_counter
  import clks_alot_p::*;
#(
  parameter int COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_start,
  input  logic                     i_advance,
  input  logic [COUNTER_WIDTH-1:0] i_rate,
  input  logic                     i_skew_en,
  input  logic [COUNTER_WIDTH-1:0] i_skew,
  output logic [COUNTER_WIDTH-1:0] o_count,
  output logic                     o_wrap
);

  logic [COUNTER_WIDTH-1:0]        r_count;
  logic [COUNTER_WIDTH-1:0]        r_target;
  logic [COUNTER_WIDTH-1:0]        w_skew;
  logic signed [COUNTER_WIDTH+1:0] w_sum;
  logic [COUNTER_WIDTH-1:0]        w_target;

  // Two guard bits so the largest rate plus a positive skew cannot wrap negative.
  assign w_skew = i_skew_en ? i_skew : '0;
  assign w_sum  = $signed({2'b00, i_rate})
                + $signed({{2{w_skew[COUNTER_WIDTH-1]}}, w_skew});

  always_comb begin
    w_target = w_sum[COUNTER_WIDTH-1:0];
    if (w_sum[COUNTER_WIDTH+1]) begin
      w_target = '0;
    end else if (w_sum[COUNTER_WIDTH]) begin
      w_target = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_target <= '0;
    end else if (i_clear) begin
      r_count  <= '0;
      r_target <= '0;
    end else if (i_start) begin
      r_count  <= '0;
      r_target <= w_target;
    end else if (i_advance) begin
      r_count  <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_wrap  = (r_count == r_target);

endmodule
`default_nettype wire

// File: rtl/clk_edge_generator.sv
`default_nettype none
// ============================================================================
// clk_edge_generator: square clock synthesiser with edge strobes and
// rate/skew valid-ready updates. Rev 1.0
// ============================================================================
module clk_edge_generator
  import clks_alot_p::*;
#(
  parameter int COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH,
  parameter int SKEW_WIDTH    = clks_alot_p::SKEW_WIDTH
) (
  input  common_p::clk_dom_s        sys_dom_i,
  input  logic                      gen_en_i,
  input  logic                      rate_valid_i,
  output logic                      rate_ready_o,
  input  logic [COUNTER_WIDTH-1:0]  half_rate_minus_one_i,
  input  logic                      skew_valid_i,
  output logic                      skew_ready_o,
  input  logic [SKEW_WIDTH-1:0]     skew_i,
  output logic                      clk_o,
  output logic                      rising_edge_o,
  output logic                      falling_edge_o,
  output logic                      any_edge_o,
  output logic [COUNTER_WIDTH-1:0]  current_rate_counter_o,
  output logic                      running_o
);

  localparam int c_pend_w = $bits(pend_s) - 1;

  logic clk;
  logic rst_n;
  assign clk   = sys_dom_i.clk;
  assign rst_n = sys_dom_i.rst_n;

  gen_state_e               r_state;
  gen_state_e               w_state_nxt;
  logic                     r_clk;
  logic                     r_rise;
  logic                     r_fall;
  logic                     r_any;
  logic                     r_running;
  logic [COUNTER_WIDTH-1:0] r_active_rate;
  pend_s                    r_rate_pend;
  pend_s                    r_skew_pend;

  logic                     w_clk_nxt;
  logic                     w_rise_nxt;
  logic                     w_fall_nxt;
  logic                     w_clear;
  logic                     w_start;
  logic                     w_advance;
  logic [COUNTER_WIDTH-1:0] w_load_rate;
  logic                     w_rate_take;
  logic                     w_skew_take;
  logic                     w_skew_drop;
  logic                     w_wrap;
  logic [COUNTER_WIDTH-1:0] w_pend_rate;
  logic [COUNTER_WIDTH-1:0] w_pend_skew;

  assign w_pend_rate = COUNTER_WIDTH'(r_rate_pend.value);
  assign w_pend_skew = COUNTER_WIDTH'(r_skew_pend.value);

  half_period_counter #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) u_half_period_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_clear),
    .i_start   (w_start),
    .i_advance (w_advance),
    .i_rate    (w_load_rate),
    .i_skew_en (w_skew_take),
    .i_skew    (w_pend_skew),
    .o_count   (current_rate_counter_o),
    .o_wrap    (w_wrap)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_clk_nxt   = r_clk;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_clear     = 1'b0;
    w_start     = 1'b0;
    w_advance   = 1'b0;
    w_load_rate = r_active_rate;
    w_rate_take = 1'b0;
    w_skew_take = 1'b0;
    w_skew_drop = 1'b0;
    case (r_state)
      IDLE: begin
        if (gen_en_i) begin
          w_state_nxt = RUN;
          w_clk_nxt   = 1'b1;
          w_rise_nxt  = 1'b1;
          w_start     = 1'b1;
          w_skew_take = r_skew_pend.valid;
          w_rate_take = r_rate_pend.valid;
          w_load_rate = r_rate_pend.valid ? w_pend_rate : half_rate_minus_one_i;
        end else begin
          w_clear = 1'b1;
        end
      end
      RUN, STOP: begin
        // STOP with the enable back behaves exactly like RUN, so no edge is lost or added.
        if (r_state == RUN || gen_en_i) begin
          w_state_nxt = gen_en_i ? RUN : STOP;
          if (w_wrap) begin
            w_clk_nxt   = !r_clk;
            w_rise_nxt  = !r_clk;
            w_fall_nxt  = r_clk;
            w_start     = 1'b1;
            w_skew_take = r_skew_pend.valid;
            if (!r_clk && r_rate_pend.valid) begin
              w_load_rate = w_pend_rate;
              w_rate_take = 1'b1;
            end
          end else begin
            w_advance = 1'b1;
          end
        end else if (!r_clk || w_wrap) begin
          w_state_nxt = IDLE;
          w_clk_nxt   = 1'b0;
          w_fall_nxt  = r_clk;
          w_clear     = 1'b1;
          w_skew_drop = 1'b1;
        end else begin
          w_advance = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_clk_nxt   = 1'b0;
        w_clear     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_clk         <= 1'b0;
      r_rise        <= 1'b0;
      r_fall        <= 1'b0;
      r_any         <= 1'b0;
      r_running     <= 1'b0;
      r_active_rate <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_clk         <= w_clk_nxt;
      r_rise        <= w_rise_nxt;
      r_fall        <= w_fall_nxt;
      r_any         <= w_rise_nxt | w_fall_nxt;
      r_running     <= (w_state_nxt != IDLE);
      r_active_rate <= w_load_rate;
    end
  end

  // A fresh transfer only happens while empty, so it never races a consume or discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rate_pend <= '0;
      r_skew_pend <= '0;
    end else begin
      if (rate_valid_i && !r_rate_pend.valid) begin
        r_rate_pend <= '{valid: 1'b1, value: c_pend_w'(half_rate_minus_one_i)};
      end else if (w_rate_take) begin
        r_rate_pend.valid <= 1'b0;
      end
      if (skew_valid_i && !r_skew_pend.valid) begin
        r_skew_pend <= '{valid: 1'b1, value: c_pend_w'($signed(skew_i))};
      end else if (w_skew_take || w_skew_drop) begin
        r_skew_pend.valid <= 1'b0;
      end
    end
  end

  assign rate_ready_o   = !r_rate_pend.valid;
  assign skew_ready_o   = !r_skew_pend.valid;
  assign clk_o          = r_clk;
  assign rising_edge_o  = r_rise;
  assign falling_edge_o = r_fall;
  assign any_edge_o     = r_any;
  assign running_o      = r_running;

endmodule
`default_nettype wire
